if_fetch_ctrl: RTL and testbench

Sequencer for the instruction-fetch stage. It owns the PC register and drives the fetch stage's pc, ram_ena, ram_wena and ram_indata inputs. It shares the single-port instruction RAM between normal fetch and a program-load port that rewrites instruction memory. It also tracks the RAM's one-cycle synchronous read latency and flags which output words are valid instructions.

---
 rtl/if_fetch_ctrl_pkg.sv | 14 +
 rtl/if_fetch_ctrl_if.sv | 42 ++++
 rtl/if_fetch_ctrl.sv | 101 ++++++++++
 tb/tb_if_fetch_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_ctrl_pkg.sv
// Shared definitions for the instruction-fetch sequencer: state encoding
// and parameter defaults.
package if_fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_LOAD  = 2'd2
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int          ADDR_W_DEFAULT   = 10;

endpackage

// File: rtl/if_fetch_ctrl_if.sv
// Bus between the fetch sequencer and its neighbours (hazard unit, fetch
// stage, program loader, instruction RAM).
//
// Load handshake: load_req is the valid and load_ack is the ready-qualified
// acceptance. A word (load_addr/load_data/load_last) transfers on a rising
// edge where load_req && load_ack. While load_req is high, the loader must
// hold the word stable until it is acked. load_ack is combinational and only
// ever high while the sequencer owns the RAM for loading.
interface if_fetch_ctrl_if #(
  parameter int ADDR_W = 10
);
  import if_fetch_ctrl_pkg::*;

  logic                stall;
  logic [31:0]         npc;
  logic                load_req;
  logic [31:0]         load_addr;
  logic [31:0]         load_data;
  logic                load_last;
  logic                load_ack;
  logic [31:0]         pc;
  logic                ram_ena;
  logic                ram_wena;
  logic [31:0]         ram_indata;
  logic [ADDR_W-1:0]   ram_addr;   // word address seen by the RAM (pc[ADDR_W+1:2])
  logic                inst_valid;
  logic                busy;
  fetch_state_e        state;      // debug view of the sequencer state

  modport master (
    output stall, npc, load_req, load_addr, load_data, load_last,
    input  load_ack, pc, ram_ena, ram_wena, ram_indata, ram_addr,
           inst_valid, busy, state
  );

  modport slave (
    input  stall, npc, load_req, load_addr, load_data, load_last,
    output load_ack, pc, ram_ena, ram_wena, ram_indata, ram_addr,
           inst_valid, busy, state
  );

endinterface

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, arbitrates the single-port
// instruction RAM between normal fetch and program loading, and tracks the
// RAM's one-cycle read latency to flag valid instruction words.
import if_fetch_ctrl_pkg::*;

module if_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          ADDR_W   = ADDR_W_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  if_fetch_ctrl_if.slave bus
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         valid_q, valid_d;
  logic [31:0]  pc_mux;
  logic         ena, wena, ack, busy;

  // State, PC and read-valid registers; reset aborts any drain/load at once.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
    end
  end

  // Next-state logic and RAM port mux.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    pc_mux  = pc_q;
    ena     = 1'b0;
    wena    = 1'b0;
    ack     = 1'b0;
    busy    = 1'b0;
    case (state_q)
      ST_RUN: begin
        // A stall freezes PC, RAM output register and the valid flag alike.
        if (!bus.stall) begin
          if (bus.load_req) begin
            // Give up the RAM: no fetch this cycle, and the pipeline sees
            // no valid words until the reloaded program is fetched.
            state_d = ST_DRAIN;
            valid_d = 1'b0;
          end else begin
            ena     = 1'b1;
            pc_d    = bus.npc;
            valid_d = 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        busy    = 1'b1;
        valid_d = 1'b0;
        state_d = ST_LOAD;
      end
      ST_LOAD: begin
        busy    = 1'b1;
        valid_d = 1'b0;
        pc_mux  = bus.load_addr;
        ena     = bus.load_req;
        wena    = bus.load_req;
        ack     = bus.load_req;
        if (bus.load_req && bus.load_last) begin
          state_d = ST_RUN;
          pc_d    = RESET_PC;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
    // The reset cycle neither acks nor writes, even mid-load.
    if (rst) begin
      pc_mux = pc_q;
      ena    = 1'b0;
      wena   = 1'b0;
      ack    = 1'b0;
      busy   = 1'b0;
    end
  end

  assign bus.pc         = pc_mux;
  assign bus.ram_addr   = pc_mux[ADDR_W+1:2];
  assign bus.ram_ena    = ena;
  assign bus.ram_wena   = wena;
  assign bus.ram_indata = bus.load_data;
  assign bus.load_ack   = ack;
  assign bus.inst_valid = valid_q;
  assign bus.busy       = busy;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Bench for if_fetch_ctrl: directed vector table, then randomized traffic
// checked against a transaction-level model of fetch/drain/load behaviour.
module tb_if_fetch_ctrl;

  localparam int ADDR_W = 10;
  localparam int WORDS  = 1 << ADDR_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  logic tb_clear;
  always #5 clk = ~clk;

  if_fetch_ctrl_if #(.ADDR_W(ADDR_W)) ifc ();

  if_fetch_ctrl #(.RESET_PC(32'h0000_0000), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  // Instruction RAM as the fetch stage sees it: single port, sync read.
  logic [31:0] mem [0:WORDS-1];
  logic [31:0] ram_out;
  always @(posedge clk) begin
    if (tb_clear) begin
      for (int i = 0; i < WORDS; i++) mem[i] <= 32'h0;
      ram_out <= 32'h0;
    end else if (ifc.ram_ena) begin
      if (ifc.ram_wena) mem[ifc.ram_addr] <= ifc.ram_indata;
      else              ram_out <= mem[ifc.ram_addr];
    end
  end

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [36:0] outs();
    return {ifc.pc, ifc.ram_ena, ifc.ram_wena, ifc.load_ack, ifc.inst_valid, ifc.busy};
  endfunction

  // ---------------- reference model ----------------
  // Mode of the model: fetching, one idle hand-over cycle, or loading.
  bit          m_draining, m_loading;
  logic [31:0] m_pc;
  bit          m_valid;
  logic [31:0] m_rd;             // word the last fetch returned
  logic [31:0] m_mem [0:WORDS-1];

  function automatic logic [36:0] model_outs(input logic r, s, lq, input logic [31:0] la);
    logic [31:0] p;
    logic e, w, a, b;
    p = m_pc; e = 0; w = 0; a = 0; b = 0;
    if (!r) begin
      if (m_loading) begin
        p = la; e = lq; w = lq; a = lq; b = 1;
      end else if (m_draining) begin
        b = 1;
      end else begin
        e = !s && !lq;
      end
    end
    return {p, e, w, a, 1'(m_valid), b};
  endfunction

  task automatic model_step(input logic r, s, lq, ll, input logic [31:0] np, la, ld);
    if (r) begin
      m_draining = 0; m_loading = 0; m_pc = 32'h0; m_valid = 0;
    end else if (m_loading) begin
      if (lq) begin
        m_mem[la[ADDR_W+1:2]] = ld;
        if (ll) begin
          m_loading = 0; m_pc = 32'h0; m_valid = 0;
        end
      end
    end else if (m_draining) begin
      m_draining = 0; m_loading = 1;
    end else if (!s) begin
      if (lq) begin
        m_draining = 1; m_valid = 0;
      end else begin
        m_rd    = m_mem[m_pc[ADDR_W+1:2]];
        m_pc    = np;
        m_valid = 1;
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic r, s, lq, ll, input logic [31:0] np, la, ld);
    @(negedge clk);
    rst           = r;
    ifc.stall     = s;
    ifc.load_req  = lq;
    ifc.load_last = ll;
    ifc.npc       = np;
    ifc.load_addr = la;
    ifc.load_data = ld;
    #1;
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic rst, stall, lreq, llast;
    logic [31:0] npc, laddr, ldata;
    logic [31:0] e_pc;
    logic e_ena, e_wena, e_ack, e_valid, e_busy;
    logic chk_ram;
    logic [31:0] e_ram;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic r, s, lq, ll, input logic [31:0] np, la, ld,
                              input logic [31:0] pc_e, input logic en_e, we_e, ak_e, va_e, bu_e,
                              input logic ck, input logic [31:0] rd_e);
    vec_t v;
    v.rst = r; v.stall = s; v.lreq = lq; v.llast = ll;
    v.npc = np; v.laddr = la; v.ldata = ld;
    v.e_pc = pc_e; v.e_ena = en_e; v.e_wena = we_e; v.e_ack = ak_e;
    v.e_valid = va_e; v.e_busy = bu_e; v.chk_ram = ck; v.e_ram = rd_e;
    return v;
  endfunction

  initial begin
    logic r, s, lq, ll;
    logic [31:0] np, la, ld;
    vec_t v;

    for (int i = 0; i < WORDS; i++) m_mem[i] = 32'h0;
    m_rd = 32'h0;
    rst = 1'b1; tb_clear = 1'b1;
    ifc.stall = 0; ifc.load_req = 0; ifc.load_last = 0;
    ifc.npc = 0; ifc.load_addr = 0; ifc.load_data = 0;
    repeat (2) begin
      drive(1, 0, 0, 0, 0, 0, 0);
      model_step(1, 0, 0, 0, 0, 0, 0);
    end
    tb_clear = 1'b0;

    //                 rst s lq ll npc           laddr  ldata           pc    en we ak va bu ck ram
    vq.push_back(mk(1, 0, 0, 0, 32'h00, 32'h00, 32'h0,          32'h00, 0, 0, 0, 0, 0, 0, 32'h0));
    // free run from reset
    vq.push_back(mk(0, 0, 0, 0, 32'h04, 32'h00, 32'h0,          32'h00, 1, 0, 0, 0, 0, 0, 32'h0));
    vq.push_back(mk(0, 0, 0, 0, 32'h08, 32'h00, 32'h0,          32'h04, 1, 0, 0, 1, 0, 0, 32'h0));
    vq.push_back(mk(0, 0, 0, 0, 32'h0C, 32'h00, 32'h0,          32'h08, 1, 0, 0, 1, 0, 0, 32'h0));
    vq.push_back(mk(0, 0, 0, 0, 32'h10, 32'h00, 32'h0,          32'h0C, 1, 0, 0, 1, 0, 0, 32'h0));
    // stall three cycles at 0x10
    vq.push_back(mk(0, 1, 0, 0, 32'h14, 32'h00, 32'h0,          32'h10, 0, 0, 0, 1, 0, 0, 32'h0));
    vq.push_back(mk(0, 1, 0, 0, 32'h14, 32'h00, 32'h0,          32'h10, 0, 0, 0, 1, 0, 0, 32'h0));
    vq.push_back(mk(0, 1, 0, 0, 32'h14, 32'h00, 32'h0,          32'h10, 0, 0, 0, 1, 0, 0, 32'h0));
    vq.push_back(mk(0, 0, 0, 0, 32'h14, 32'h00, 32'h0,          32'h10, 1, 0, 0, 1, 0, 0, 32'h0));
    vq.push_back(mk(0, 0, 0, 0, 32'h18, 32'h00, 32'h0,          32'h14, 1, 0, 0, 1, 0, 0, 32'h0));
    // load request while stalled: stall wins
    vq.push_back(mk(0, 1, 1, 0, 32'h1C, 32'h00, 32'h20080001,   32'h18, 0, 0, 0, 1, 0, 0, 32'h0));
    vq.push_back(mk(0, 1, 1, 0, 32'h1C, 32'h00, 32'h20080001,   32'h18, 0, 0, 0, 1, 0, 0, 32'h0));
    vq.push_back(mk(0, 0, 1, 0, 32'h1C, 32'h00, 32'h20080001,   32'h18, 0, 0, 0, 1, 0, 0, 32'h0));
    // drain, then gapped three-word load
    vq.push_back(mk(0, 0, 1, 0, 32'h1C, 32'h00, 32'h20080001,   32'h18, 0, 0, 0, 0, 1, 0, 32'h0));
    vq.push_back(mk(0, 0, 1, 0, 32'h1C, 32'h00, 32'h20080001,   32'h00, 1, 1, 1, 0, 1, 0, 32'h0));
    vq.push_back(mk(0, 0, 0, 0, 32'h1C, 32'h04, 32'h20090002,   32'h04, 0, 0, 0, 0, 1, 0, 32'h0));
    vq.push_back(mk(0, 0, 1, 0, 32'h1C, 32'h04, 32'h20090002,   32'h04, 1, 1, 1, 0, 1, 0, 32'h0));
    vq.push_back(mk(0, 0, 1, 1, 32'h1C, 32'h08, 32'h01095020,   32'h08, 1, 1, 1, 0, 1, 0, 32'h0));
    // restart at RESET_PC and read back the program
    vq.push_back(mk(0, 0, 0, 0, 32'h04, 32'h00, 32'h0,          32'h00, 1, 0, 0, 0, 0, 0, 32'h0));
    vq.push_back(mk(0, 0, 0, 0, 32'h08, 32'h00, 32'h0,          32'h04, 1, 0, 0, 1, 0, 1, 32'h20080001));
    vq.push_back(mk(0, 0, 0, 0, 32'h0C, 32'h00, 32'h0,          32'h08, 1, 0, 0, 1, 0, 1, 32'h20090002));
    vq.push_back(mk(0, 0, 0, 0, 32'h10, 32'h00, 32'h0,          32'h0C, 1, 0, 0, 1, 0, 1, 32'h01095020));
    // second load aborted by reset in its second load cycle
    vq.push_back(mk(0, 0, 1, 0, 32'h14, 32'h40, 32'hAAAA0001,   32'h10, 0, 0, 0, 1, 0, 1, 32'h0));
    vq.push_back(mk(0, 0, 1, 0, 32'h14, 32'h40, 32'hAAAA0001,   32'h10, 0, 0, 0, 0, 1, 0, 32'h0));
    vq.push_back(mk(0, 0, 1, 0, 32'h14, 32'h40, 32'hAAAA0001,   32'h40, 1, 1, 1, 0, 1, 0, 32'h0));
    vq.push_back(mk(1, 0, 1, 0, 32'h14, 32'h44, 32'hBBBB0002,   32'h10, 0, 0, 0, 0, 0, 0, 32'h0));
    vq.push_back(mk(0, 0, 0, 0, 32'h40, 32'h00, 32'h0,          32'h00, 1, 0, 0, 0, 0, 0, 32'h0));
    vq.push_back(mk(0, 0, 0, 0, 32'h44, 32'h00, 32'h0,          32'h40, 1, 0, 0, 1, 0, 1, 32'h20080001));
    vq.push_back(mk(0, 0, 0, 0, 32'h48, 32'h00, 32'h0,          32'h44, 1, 0, 0, 1, 0, 1, 32'hAAAA0001));
    vq.push_back(mk(0, 0, 0, 0, 32'h4C, 32'h00, 32'h0,          32'h48, 1, 0, 0, 1, 0, 1, 32'h00000000));

    for (int i = 0; i < vq.size(); i++) begin
      v = vq[i];
      drive(v.rst, v.stall, v.lreq, v.llast, v.npc, v.laddr, v.ldata);
      check($sformatf("vec%0d_outs", i), outs(),
            {v.e_pc, v.e_ena, v.e_wena, v.e_ack, v.e_valid, v.e_busy});
      if (v.chk_ram) check($sformatf("vec%0d_ram", i), ram_out, v.e_ram);
      model_step(v.rst, v.stall, v.lreq, v.llast, v.npc, v.laddr, v.ldata);
    end

    // ---------------- randomized traffic against the model ----------------
    for (int c = 0; c < 400; c++) begin
      r  = ($urandom_range(0, 99) < 2);
      s  = ($urandom_range(0, 3) == 0);
      if (m_loading) begin
        lq = ($urandom_range(0, 9) < 7);
        ll = ($urandom_range(0, 4) == 0);
      end else begin
        lq = ($urandom_range(0, 14) == 0);
        ll = 1'($urandom_range(0, 1));
      end
      np = m_pc + 32'd4;
      if ($urandom_range(0, 9) == 0) np = $urandom() & 32'hFFFF_FFFC;
      if ($urandom_range(0, 49) == 0) np = 32'hFFFF_FFFC;
      la = $urandom();
      ld = $urandom();
      drive(r, s, lq, ll, np, la, ld);
      check($sformatf("rnd%0d_outs", c), outs(), model_outs(r, s, lq, la));
      if (m_valid) check($sformatf("rnd%0d_ram", c), ram_out, m_rd);
      model_step(r, s, lq, ll, np, la, ld);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
